// File: rtl/sweep_pkg.sv
// rtl/sweep_pkg.sv - shared state encoding and default sizing for the truth-table sweeper
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_e;

  localparam int N_IN_DEFAULT          = 4;
  localparam int N_VEC                 = 2 ** N_IN_DEFAULT;
  localparam int SETTLE_CYCLES_DEFAULT = 1;

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - settle down-counter, loaded on DRIVE entry, expires at count 1
module sweep_settle_timer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = 4;

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= CW'(SETTLE_CYCLES);
    end else if (en_i && (count_q > CW'(1))) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign expire_o = en_i && (count_q == CW'(1));

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps every input vector of a function, captures and scores its truth table
// Optional early abort on a mismatch threshold: define SWEEP_EARLY_ABORT_EN.
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEFAULT,
  parameter int N_IN          = N_IN_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [(2**N_IN)-1:0]  target,
  output logic [N_IN-1:0]       fn_in,
  input  logic                  fn_out,
  output logic                  busy,
  output logic                  done,
  output logic [(2**N_IN)-1:0]  captured,
  output logic [N_IN:0]         mismatch_count,
  output logic                  pass
`ifdef SWEEP_EARLY_ABORT_EN
  ,
  input  logic [N_IN:0]         abort_thresh
`endif
);

  localparam int NV = 2 ** N_IN;

  sweep_state_e      state_q;
  logic [N_IN-1:0]   idx_q;
  logic [NV-1:0]     tgt_q;
  logic [NV-1:0]     captured_q;
  logic [N_IN:0]     mm_q;
  logic [N_IN:0]     mm_d;
  logic [N_IN-1:0]   fn_in_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic              last_vec;
  logic              abort_d;
  logic              timer_load;
  logic              timer_expire;

  always_comb begin
    mm_d = mm_q;
    if ((fn_out != tgt_q[idx_q]) && (mm_q != (N_IN+1)'(NV))) begin
      mm_d = mm_q + 1'b1;
    end
    last_vec = &idx_q;
`ifdef SWEEP_EARLY_ABORT_EN
    abort_d = (abort_thresh != '0) && (mm_d >= abort_thresh);
`else
    abort_d = 1'b0;
`endif
  end

  // Timer reloads on every entry into DRIVE, from IDLE or from a non-final SAMPLE.
  assign timer_load = ((state_q == IDLE) && start) ||
                      ((state_q == SAMPLE) && !last_vec && !abort_d);

  sweep_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .en_i     (state_q == DRIVE),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      tgt_q      <= '0;
      captured_q <= '0;
      mm_q       <= '0;
      fn_in_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            tgt_q      <= target;
            captured_q <= '0;
            mm_q       <= '0;
            idx_q      <= '0;
            fn_in_q    <= '0;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            state_q    <= DRIVE;
          end
        end
        DRIVE: begin
          if (timer_expire) begin
            state_q <= SAMPLE;
          end
        end
        SAMPLE: begin
          captured_q[idx_q] <= fn_out;
          mm_q              <= mm_d;
          if (last_vec || abort_d) begin
            fn_in_q <= '0;
            state_q <= DONE;
          end else begin
            idx_q   <= idx_q + 1'b1;
            fn_in_q <= idx_q + 1'b1;
            state_q <= DRIVE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= (mm_q == '0);
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fn_in          = fn_in_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign captured       = captured_q;
  assign mismatch_count = mm_q;
  assign pass           = pass_q;

endmodule

// File: doc/truth_table_sweeper.md
TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 1, giving the cycles each input vector is held before sampling (legal range 1..15).
REQ-002 The block SHALL have parameter N_IN, default 4, giving the function input width; it fixes 2**N_IN vectors per sweep.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: sweep request, sampled only in IDLE.
REQ-006 The block SHALL have port target, input, 2**N_IN bits: expected truth table, bit i is the expected output for vector i.
REQ-007 The block SHALL have port fn_in, output, N_IN bits: vector driven to the combinational function under test.
REQ-008 The block SHALL have port fn_out, input, 1 bit: function-under-test response.
REQ-009 The block SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done is asserted.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 The block SHALL have port captured, output, 2**N_IN bits: measured truth table.
REQ-012 The block SHALL have port mismatch_count, output, N_IN+1 bits: number of vectors where fn_out differed from target.
REQ-013 The block SHALL have port pass, output, 1 bit: high when mismatch_count is zero, valid while done is high and held until the next start.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 In IDLE, start=1 SHALL latch target, clear captured and mismatch_count, set the vector index to 0, and move to DRIVE.
REQ-016 DRIVE SHALL hold fn_in equal to the index for SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-017 SAMPLE SHALL last one cycle, with fn_in still equal to the index.
REQ-018 At the end of SAMPLE, the block SHALL write fn_out into captured[index] and increment mismatch_count when fn_out differs from latched target[index].
REQ-019 At the end of SAMPLE, if the index is less than 2**N_IN-1, the block SHALL increment the index and return to DRIVE; otherwise it SHALL go to DONE.
REQ-020 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-021 With defaults, done SHALL be high exactly 33 cycles after the edge that accepted start.
REQ-022 The index SHALL end the sweep at 2**N_IN-1 and SHALL never wrap to 0 inside a sweep.
REQ-023 mismatch_count SHALL saturate at 2**N_IN, which its width always represents.
REQ-024 start while busy SHALL be ignored, and target changes during a sweep SHALL have no effect.
REQ-025 start high in the DONE cycle SHALL be ignored; start held high SHALL launch a new sweep from IDLE on the next cycle.
REQ-026 fn_in SHALL be 0 in IDLE and DONE.

Reset
REQ-027 rst_n low SHALL immediately force state IDLE, and set fn_in, busy, done, pass, captured, mismatch_count and the index to 0.
REQ-028 Reset asserted mid-sweep SHALL discard partial results; after release the block SHALL wait in IDLE for start.

Configuration
REQ-029 Macro SWEEP_EARLY_ABORT_EN SHALL enable an early-abort feature.
REQ-030 When SWEEP_EARLY_ABORT_EN is defined, the block SHALL add input abort_thresh (N_IN+1 bits).
REQ-031 When SWEEP_EARLY_ABORT_EN is defined and mismatch_count reaches a nonzero abort_thresh at the end of SAMPLE, the block SHALL go directly to DONE with pass=0; unswept captured bits SHALL remain 0.
REQ-032 When SWEEP_EARLY_ABORT_EN is defined, abort_thresh=0 SHALL disable the abort.
REQ-033 When SWEEP_EARLY_ABORT_EN is undefined, there SHALL be no port and every sweep SHALL run all vectors.

Structure
REQ-034 Package sweep_pkg SHALL hold the FSM state enum typedef, the N_VEC=2**N_IN constant, and the default SETTLE_CYCLES.
REQ-035 Sub-module sweep_settle_timer SHALL be a down-counter loaded with SETTLE_CYCLES on DRIVE entry, asserting expire at count 1.
REQ-036 The function under test SHALL be instantiated by the testbench, not inside this block.

Verification
REQ-037 Bench: function output 1 only for vectors 13 and 14, target=16'h6000, start -> done at cycle 33, captured=16'h6000, mismatch_count=0, pass=1.
REQ-038 Bench: same function, target=16'h6001 -> mismatch_count=1, pass=0, captured=16'h6000.
REQ-039 Bench: reset pulsed at cycle 10 of a sweep -> all outputs 0 immediately; new start gives a full correct sweep.
REQ-040 Bench: start re-pulsed at cycles 5 and 20 of a sweep -> ignored, single done at cycle 33.
REQ-041 Bench: SETTLE_CYCLES=3 -> each vector held 4 cycles, done at cycle 65; fn_in sequence 0..15 monotonic.
REQ-042 Bench: with SWEEP_EARLY_ABORT_EN, abort_thresh=2, function constant 1, target=0 -> done after vector 1 (cycle 5), mismatch_count=2, captured=16'h0003, pass=0.
